// File: rtl/coherence_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared coherence bus: one owner at a time, held until bus_ack_i.
// Optional watchdog abort of a stalled grant is enabled by defining ARB_TIMEOUT_EN.
module coherence_bus_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CORES-1:0]         req_i,
   input  logic                         bus_ack_i,
   output logic [NUM_CORES-1:0]         gnt_o,
   output logic [$clog2(NUM_CORES)-1:0] bus_owner_o,
   output logic                         bus_valid_o,
   output logic [NUM_CORES-1:0]         done_o,
   output logic                         busy_o,
   output logic                         timeout_o
);

   localparam int OW = $clog2(NUM_CORES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   logic [NUM_CORES-1:0]  r_gnt;
   logic [OW-1:0]         r_owner;
   logic                  r_valid;
   logic [NUM_CORES-1:0]  r_done;
   logic                  r_busy;
   logic [OW-1:0]         r_rr_last;

   logic                  w_found;
   logic [OW-1:0]         w_pick;
   logic [NUM_CORES-1:0]  w_pick_oh;
   logic                  w_owner_req;

   // Scan downward in offset so the smallest offset from rr_last+1 is the last (winning) assignment.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         if (req_i[(int'(r_rr_last) + k) % NUM_CORES]) begin
            w_found = 1'b1;
            w_pick  = OW'((int'(r_rr_last) + k) % NUM_CORES);
         end
      end
   end

   assign w_pick_oh   = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_pick;
   assign w_owner_req = req_i[r_owner];

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   logic          r_timeout;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_owner   <= '0;
         r_valid   <= 1'b0;
         r_done    <= '0;
         r_busy    <= 1'b0;
         r_rr_last <= OW'(NUM_CORES - 1);
`ifdef ARB_TIMEOUT_EN
         r_cnt     <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         r_done <= '0;
`ifdef ARB_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_GRANT;
                  r_gnt   <= w_pick_oh;
                  r_owner <= w_pick;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            S_GRANT: begin
               // Ack has priority over both abandon and watchdog expiry.
               if (bus_ack_i) begin
                  r_state   <= S_DONE;
                  r_done    <= r_gnt;
                  r_gnt     <= '0;
                  r_valid   <= 1'b0;
                  r_rr_last <= r_owner;
               end else if (!w_owner_req) begin
                  r_state   <= S_IDLE;
                  r_gnt     <= '0;
                  r_valid   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_rr_last <= r_owner;
               end
`ifdef ARB_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_state   <= S_IDLE;
                  r_gnt     <= '0;
                  r_valid   <= 1'b0;
                  r_busy    <= 1'b0;
                  r_rr_last <= r_owner;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o       = r_gnt;
   assign bus_owner_o = r_owner;
   assign bus_valid_o = r_valid;
   assign done_o      = r_done;
   assign busy_o      = r_busy;
`ifdef ARB_TIMEOUT_EN
   assign timeout_o   = r_timeout;
`else
   assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed self-checking bench for coherence_bus_arbiter (NUM_CORES=2, TIMEOUT=4).
// Covers reset, single transaction, round-robin, abandon, ack/abandon race and the watchdog.
module tb_coherence_bus_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] req_i;
   logic       bus_ack_i;
   logic [1:0] gnt_o;
   logic [0:0] bus_owner_o;
   logic       bus_valid_o;
   logic [1:0] done_o;
   logic       busy_o;
   logic       timeout_o;

   int n_checks;
   int n_errors;

   coherence_bus_arbiter #(
      .NUM_CORES (2),
      .TIMEOUT   (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req_i),
      .bus_ack_i   (bus_ack_i),
      .gnt_o       (gnt_o),
      .bus_owner_o (bus_owner_o),
      .bus_valid_o (bus_valid_o),
      .done_o      (done_o),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] gnt, input logic [1:0] done,
                             input logic busy);
      check_value({tag, ".gnt"},   32'(gnt_o),       32'(gnt));
      check_value({tag, ".done"},  32'(done_o),      32'(done));
      check_value({tag, ".valid"}, 32'(bus_valid_o), 32'(|gnt));
      check_value({tag, ".busy"},  32'(busy_o),      32'(busy));
      check_value({tag, ".tmo"},   32'(timeout_o),   32'd0);
   endtask

   logic [1:0] exp_order [4];

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b0;
      req_i     = 2'b00;
      bus_ack_i = 1'b0;
      exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};

      // T1: reset state, async clear mid-grant, core 0 first after release
      tick(); tick();
      check_outs("t1_rst", 2'b00, 2'b00, 1'b0);
      check_value("t1_rst.owner", 32'(bus_owner_o), 32'd0);
      reset = 1'b1;
      req_i = 2'b11;
      tick();
      check_outs("t1_gnt", 2'b01, 2'b00, 1'b1);
      reset = 1'b0;
      #1;
      check_outs("t1_async", 2'b00, 2'b00, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check_outs("t1_first", 2'b01, 2'b00, 1'b1);
      check_value("t1_first.owner", 32'(bus_owner_o), 32'd0);
      bus_ack_i = 1'b1;
      tick();
      check_outs("t1_done", 2'b00, 2'b01, 1'b1);
      bus_ack_i = 1'b0;
      req_i     = 2'b00;
      tick();
      check_outs("t1_idle", 2'b00, 2'b00, 1'b0);
      $display("txn T1 reset: core0 granted first after release");

      // T2: single request from core 1
      req_i = 2'b10;
      tick();
      check_outs("t2_e1", 2'b10, 2'b00, 1'b1);
      check_value("t2_e1.owner", 32'(bus_owner_o), 32'd1);
      tick();
      check_outs("t2_e2", 2'b10, 2'b00, 1'b1);
      bus_ack_i = 1'b1;
      tick();
      check_outs("t2_e4", 2'b00, 2'b10, 1'b1);
      bus_ack_i = 1'b0;
      req_i     = 2'b00;
      tick();
      check_outs("t2_e5", 2'b00, 2'b00, 1'b0);
      $display("txn T2 single: core1 done");

      // T3: both requesting continuously, ack two cycles after each grant
      req_i = 2'b11;
      tick();
      for (int g = 0; g < 4; g++) begin
         check_outs($sformatf("t3_gnt%0d", g), exp_order[g], 2'b00, 1'b1);
         tick();
         check_value($sformatf("t3_hold%0d", g), 32'(gnt_o), 32'(exp_order[g]));
         bus_ack_i = 1'b1;
         tick();
         bus_ack_i = 1'b0;
         check_outs($sformatf("t3_done%0d", g), 2'b00, exp_order[g], 1'b1);
         if (g == 3) req_i = 2'b00;
         tick();
         check_outs($sformatf("t3_idle%0d", g), 2'b00, 2'b00, 1'b0);
         $display("txn T3 rr: grant %0d to gnt=%b", g, exp_order[g]);
         if (g < 3) tick();
      end

      // T4: core 0 abandons, pending core 1 follows one cycle later
      req_i = 2'b01;
      tick();
      check_outs("t4_gnt0", 2'b01, 2'b00, 1'b1);
      req_i = 2'b10;
      tick();
      check_outs("t4_abandon", 2'b00, 2'b00, 1'b0);
      tick();
      check_outs("t4_gnt1", 2'b10, 2'b00, 1'b1);
      bus_ack_i = 1'b1;
      tick();
      check_outs("t4_done1", 2'b00, 2'b10, 1'b1);
      bus_ack_i = 1'b0;
      req_i     = 2'b00;
      tick();
      $display("txn T4 abandon: core0 dropped, core1 done");

      // T5: ack and abandon in the same cycle, ack wins
      req_i = 2'b01;
      tick();
      check_outs("t5_gnt", 2'b01, 2'b00, 1'b1);
      req_i     = 2'b00;
      bus_ack_i = 1'b1;
      tick();
      check_outs("t5_done", 2'b00, 2'b01, 1'b1);
      bus_ack_i = 1'b0;
      tick();
      check_outs("t5_idle", 2'b00, 2'b00, 1'b0);
      $display("txn T5 ack+abandon: done issued");

      // T6: no ack at all
      req_i = 2'b01;
      tick();
      check_outs("t6_gnt", 2'b01, 2'b00, 1'b1);
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c <= 3; c++) begin
         tick();
         check_outs($sformatf("t6_wait%0d", c), 2'b01, 2'b00, 1'b1);
      end
      tick();
      check_value("t6_tmo.pulse", 32'(timeout_o), 32'd1);
      check_value("t6_tmo.gnt",   32'(gnt_o),     32'd0);
      check_value("t6_tmo.done",  32'(done_o),    32'd0);
      check_value("t6_tmo.busy",  32'(busy_o),    32'd0);
      req_i = 2'b00;
      tick();
      check_outs("t6_after", 2'b00, 2'b00, 1'b0);
      $display("txn T6 watchdog: timeout after 4 grant cycles");
`else
      for (int c = 1; c <= 100; c++) begin
         tick();
         check_value($sformatf("t6_hold%0d", c), 32'(gnt_o), 32'b01);
         check_value($sformatf("t6_tmo%0d", c), 32'(timeout_o), 32'd0);
      end
      bus_ack_i = 1'b1;
      tick();
      check_outs("t6_done", 2'b00, 2'b01, 1'b1);
      bus_ack_i = 1'b0;
      req_i     = 2'b00;
      tick();
      $display("txn T6 no watchdog: grant held 100 cycles");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
